// File: rtl/psx_host_port.sv
// rtl/psx_host_port.sv - PSX/PS2 serial host port: byte handshake bus to SEL/CLK/CMD packets
module psx_host_port #(
    parameter int CLOCK_MHZ      = 25,
    parameter int HALF_BIT_US    = 2,
    parameter int SEL_SETUP_US   = 4,
    parameter int ACK_TIMEOUT_US = 100
) (
    input  logic       clk,
    input  logic       reset,
    output logic       PSX_clk,
    output logic       PSX_sel,
    output logic       PSX_cmd,
    input  logic       PSX_dat,
    input  logic       PSX_ack,
    input  logic [7:0] HPB_cmd,
    input  logic       HPB_cmd_last,
    input  logic       HPB_cmd_valid,
    output logic       HPB_cmd_ready,
    input  logic       HPB_packet_end,
    output logic [7:0] HPB_reply,
    output logic       HPB_reply_acked,
    output logic       HPB_reply_strobe,
    output logic       HPB_busy
);

    // Timing constants in system clock cycles; the timer is 16 bits wide.
    localparam logic [15:0] HALF_CYC  = 16'(CLOCK_MHZ * HALF_BIT_US);
    localparam logic [15:0] SETUP_CYC = 16'(CLOCK_MHZ * SEL_SETUP_US);
    localparam logic [15:0] TMO_CYC   = 16'(CLOCK_MHZ * ACK_TIMEOUT_US);

    // GAP is the half-bit pause before the first CLK fall of a follow-on byte;
    // TAIL is the half-bit pause before SEL is released after the last byte.
    typedef enum logic [2:0] {
        IDLE, SETUP, GAP, SHIFT, TAIL, ACK_WAIT, BYTE_WAIT
    } state_t;

    state_t      state, state_n;
    logic [15:0] timer, timer_n, timer_inc;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic [7:0]  rx, rx_n;
    logic [7:0]  reply_n;
    logic        last_flag, last_flag_n;
    logic        psx_clk_n, sel_n, cmd_n, acked_n, strobe_n;
    logic        do_fall;
    logic        dat_meta, sync_dat, ack_meta, sync_ack, prev_ack;
    logic        accept, ack_fall;

    assign HPB_cmd_ready = (state == IDLE) || (state == BYTE_WAIT && !HPB_packet_end);
    assign HPB_busy      = (state != IDLE);
    assign accept        = HPB_cmd_valid && HPB_cmd_ready;
    assign ack_fall      = prev_ack && !sync_ack;
    assign timer_inc     = timer + 16'd1;

    // Two-flop synchronizers for the open-collector device lines, plus ACK edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            dat_meta <= 1'b1;
            sync_dat <= 1'b1;
            ack_meta <= 1'b1;
            sync_ack <= 1'b1;
            prev_ack <= 1'b1;
        end else begin
            dat_meta <= PSX_dat;
            sync_dat <= dat_meta;
            ack_meta <= PSX_ack;
            sync_ack <= ack_meta;
            prev_ack <= sync_ack;
        end
    end

    // State and registered outputs; reset releases the bus immediately and drops any pending strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            timer            <= 16'd0;
            bit_cnt          <= 3'd0;
            shreg            <= 8'hFF;
            rx               <= 8'h00;
            last_flag        <= 1'b0;
            PSX_clk          <= 1'b1;
            PSX_sel          <= 1'b1;
            PSX_cmd          <= 1'b1;
            HPB_reply        <= 8'h00;
            HPB_reply_acked  <= 1'b0;
            HPB_reply_strobe <= 1'b0;
        end else begin
            state            <= state_n;
            timer            <= timer_n;
            bit_cnt          <= bit_cnt_n;
            shreg            <= shreg_n;
            rx               <= rx_n;
            last_flag        <= last_flag_n;
            PSX_clk          <= psx_clk_n;
            PSX_sel          <= sel_n;
            PSX_cmd          <= cmd_n;
            HPB_reply        <= reply_n;
            HPB_reply_acked  <= acked_n;
            HPB_reply_strobe <= strobe_n;
        end
    end

    // Next-state and next-output logic for the packet sequencer.
    always_comb begin
        state_n     = state;
        timer_n     = timer_inc;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        rx_n        = rx;
        last_flag_n = last_flag;
        psx_clk_n   = PSX_clk;
        sel_n       = PSX_sel;
        cmd_n       = PSX_cmd;
        reply_n     = HPB_reply;
        acked_n     = HPB_reply_acked;
        strobe_n    = 1'b0;
        do_fall     = 1'b0;

        if (accept) begin
            shreg_n     = HPB_cmd;
            last_flag_n = HPB_cmd_last;
        end

        case (state)
            IDLE: begin
                timer_n = 16'd0;
                if (accept) begin
                    sel_n   = 1'b0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (timer_inc == SETUP_CYC) begin
                    do_fall   = 1'b1;
                    timer_n   = 16'd0;
                    bit_cnt_n = 3'd0;
                    state_n   = SHIFT;
                end
            end
            GAP: begin
                if (timer_inc == HALF_CYC) begin
                    do_fall   = 1'b1;
                    timer_n   = 16'd0;
                    bit_cnt_n = 3'd0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (timer_inc == HALF_CYC) begin
                    timer_n = 16'd0;
                    if (!PSX_clk) begin
                        // Rising edge: the device bit is sampled and enters at the MSB.
                        psx_clk_n = 1'b1;
                        rx_n      = {sync_dat, rx[7:1]};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            cmd_n   = 1'b1;
                            state_n = last_flag ? TAIL : ACK_WAIT;
                        end
                    end else begin
                        do_fall = 1'b1;
                    end
                end
            end
            TAIL: begin
                if (timer_inc == HALF_CYC) begin
                    sel_n    = 1'b1;
                    strobe_n = 1'b1;
                    reply_n  = rx;
                    acked_n  = 1'b0;
                    state_n  = IDLE;
                end
            end
            ACK_WAIT: begin
                // An ACK edge beats a timeout landing in the same cycle.
                if (ack_fall) begin
                    strobe_n = 1'b1;
                    reply_n  = rx;
                    acked_n  = 1'b1;
                    state_n  = BYTE_WAIT;
                end else if (timer_inc == TMO_CYC) begin
                    strobe_n = 1'b1;
                    reply_n  = rx;
                    acked_n  = 1'b0;
                    sel_n    = 1'b1;
                    state_n  = IDLE;
                end
            end
            BYTE_WAIT: begin
                timer_n = 16'd0;
                if (HPB_packet_end) begin
                    sel_n   = 1'b1;
                    state_n = IDLE;
                end else if (accept) begin
                    state_n = GAP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Falling edge: CLK low and the next command bit (LSB first) on the same edge.
        if (do_fall) begin
            psx_clk_n = 1'b0;
            cmd_n     = shreg[0];
            shreg_n   = {1'b1, shreg[7:1]};
        end
    end

endmodule

// File: tb/tb_psx_host_port.sv
// tb/tb_psx_host_port.sv - directed bench for psx_host_port with a behavioural device model
module tb_psx_host_port;

    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       PSX_clk, PSX_sel, PSX_cmd;
    logic       PSX_dat = 1'b1;
    logic       PSX_ack = 1'b1;
    logic [7:0] HPB_cmd = 8'h00;
    logic       HPB_cmd_last = 1'b0;
    logic       HPB_cmd_valid = 1'b0;
    logic       HPB_cmd_ready;
    logic       HPB_packet_end = 1'b0;
    logic [7:0] HPB_reply;
    logic       HPB_reply_acked;
    logic       HPB_reply_strobe;
    logic       HPB_busy;

    int checks = 0;
    int errors = 0;

    psx_host_port dut (
        .clk              (clk),
        .reset            (reset),
        .PSX_clk          (PSX_clk),
        .PSX_sel          (PSX_sel),
        .PSX_cmd          (PSX_cmd),
        .PSX_dat          (PSX_dat),
        .PSX_ack          (PSX_ack),
        .HPB_cmd          (HPB_cmd),
        .HPB_cmd_last     (HPB_cmd_last),
        .HPB_cmd_valid    (HPB_cmd_valid),
        .HPB_cmd_ready    (HPB_cmd_ready),
        .HPB_packet_end   (HPB_packet_end),
        .HPB_reply        (HPB_reply),
        .HPB_reply_acked  (HPB_reply_acked),
        .HPB_reply_strobe (HPB_reply_strobe),
        .HPB_busy         (HPB_busy)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ack_mode: 0 no ACK, 1 pulse ack_dly cycles after the 8th rise,
    // 2 held low from the 4th rise, high at +125, falling again at +250.
    task automatic send_byte(input logic [7:0] c, input logic l, input logic [7:0] dev,
                             input int ack_mode, input int ack_dly,
                             input logic [7:0] exp_reply, input logic exp_acked,
                             input int exp_lead, input int exp_tail);
        int n, t_fall, t_rise, falls, rises, bad, lead, tail;
        logic [7:0] got_cmd;
        logic prev_clk, done;
        @(negedge clk);
        chk("ready_before", int'(HPB_cmd_ready), 1);
        HPB_cmd = c; HPB_cmd_last = l; HPB_cmd_valid = 1'b1;
        @(negedge clk);
        HPB_cmd_valid = 1'b0;
        chk("sel_low", int'(PSX_sel), 0);
        n = 0; t_fall = 0; t_rise = 0; falls = 0; rises = 0; bad = 0;
        lead = -1; tail = -1; got_cmd = 8'h00; prev_clk = 1'b1; done = 1'b0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
            if (prev_clk && !PSX_clk) begin
                if (falls == 0) lead = n;
                else if (n - t_rise != HALF) bad++;
                if (falls < 8) begin
                    got_cmd[falls] = PSX_cmd;
                    PSX_dat = dev[falls];
                end
                falls++;
                t_fall = n;
            end
            if (!prev_clk && PSX_clk) begin
                if (n - t_fall != HALF) bad++;
                rises++;
                t_rise = n;
                if (rises == 4 && ack_mode == 2) PSX_ack = 1'b0;
            end
            prev_clk = PSX_clk;
            if (rises == 8) begin
                if (ack_mode == 1 && n - t_rise == ack_dly)      PSX_ack = 1'b0;
                if (ack_mode == 1 && n - t_rise == ack_dly + 10) PSX_ack = 1'b1;
                if (ack_mode == 2 && n - t_rise == 125)          PSX_ack = 1'b1;
                if (ack_mode == 2 && n - t_rise == 250)          PSX_ack = 1'b0;
                if (ack_mode == 2 && n - t_rise == 260)          PSX_ack = 1'b1;
            end
            if (HPB_reply_strobe) begin
                done = 1'b1;
                tail = n - t_rise;
                chk("reply", int'(HPB_reply), int'(exp_reply));
                chk("acked", int'(HPB_reply_acked), int'(exp_acked));
            end
        end
        PSX_ack = 1'b1;
        PSX_dat = 1'b1;
        chk("strobe_seen", int'(done), 1);
        chk("lead", lead, exp_lead);
        chk("falls", falls, 8);
        chk("phase_errs", bad, 0);
        chk("cmd_bits", int'(got_cmd), int'(c));
        chk("tail", tail, exp_tail);
        chk("cmd_idle", int'(PSX_cmd), 1);
        @(negedge clk);
        chk("strobe_1cyc", int'(HPB_reply_strobe), 0);
        chk("reply_hold", int'(HPB_reply), int'(exp_reply));
    endtask

    typedef struct {
        logic [7:0] c;
        logic       l;
        logic [7:0] dev;
        int         mode;
        int         dly;
        logic [7:0] er;
        logic       ea;
        int         lead;
        int         tail;
    } vec_t;

    vec_t vecs[5];
    int   cnt, n, lows;
    logic pc;

    // Main stimulus: reset state, table of packets, then multi-cycle corner cases.
    initial begin
        vecs[0] = '{8'h01, 1'b0, 8'hFF, 1, 200, 8'hFF, 1'b1, 100, 203};
        vecs[1] = '{8'h42, 1'b0, 8'h41, 1,  50, 8'h41, 1'b1,  50,  53};
        vecs[2] = '{8'h00, 1'b1, 8'h5A, 0,   0, 8'h5A, 1'b0,  50,  50};
        vecs[3] = '{8'hA5, 1'b0, 8'h3C, 1, 100, 8'h3C, 1'b1, 100, 103};
        vecs[4] = '{8'h5A, 1'b1, 8'hC3, 0,   0, 8'hC3, 1'b0,  50,  50};

        repeat (3) @(negedge clk);
        chk("rst_clk", int'(PSX_clk), 1);
        chk("rst_sel", int'(PSX_sel), 1);
        chk("rst_cmd", int'(PSX_cmd), 1);
        chk("rst_reply", int'(HPB_reply), 0);
        chk("rst_acked", int'(HPB_reply_acked), 0);
        chk("rst_strobe", int'(HPB_reply_strobe), 0);
        chk("rst_busy", int'(HPB_busy), 0);
        chk("rst_ready", int'(HPB_cmd_ready), 1);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].c, vecs[i].l, vecs[i].dev, vecs[i].mode, vecs[i].dly,
                      vecs[i].er, vecs[i].ea, vecs[i].lead, vecs[i].tail);
            if (vecs[i].l) begin
                chk("end_sel_high", int'(PSX_sel), 1);
                chk("end_idle", int'(HPB_busy), 0);
            end else begin
                chk("bw_sel_low", int'(PSX_sel), 0);
                chk("bw_ready", int'(HPB_cmd_ready), 1);
            end
        end

        // ACK never arrives: timeout aborts the packet.
        send_byte(8'h77, 1'b0, 8'h00, 0, 0, 8'h00, 1'b0, 100, 2500);
        chk("tmo_sel", int'(PSX_sel), 1);
        chk("tmo_busy", int'(HPB_busy), 0);

        // ACK already low on entry: only the later falling edge counts.
        send_byte(8'h81, 1'b0, 8'hE7, 2, 0, 8'hE7, 1'b1, 100, 253);
        chk("prelow_sel", int'(PSX_sel), 0);

        // packet_end with a valid byte in BYTE_WAIT: packet closes, byte not taken.
        @(negedge clk);
        HPB_cmd = 8'h11; HPB_cmd_valid = 1'b1; HPB_packet_end = 1'b1;
        #1;
        chk("pe_ready", int'(HPB_cmd_ready), 0);
        @(negedge clk);
        HPB_cmd_valid = 1'b0; HPB_packet_end = 1'b0;
        chk("pe_sel", int'(PSX_sel), 1);
        chk("pe_busy", int'(HPB_busy), 0);
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!PSX_clk || HPB_busy) lows++;
        end
        chk("pe_no_clk", lows, 0);

        // Reset in the middle of bit 4.
        @(negedge clk);
        HPB_cmd = 8'hFF; HPB_cmd_last = 1'b0; HPB_cmd_valid = 1'b1;
        @(negedge clk);
        HPB_cmd_valid = 1'b0;
        cnt = 0; n = 0; pc = 1'b1;
        while (cnt < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (pc && !PSX_clk) cnt++;
            pc = PSX_clk;
        end
        chk("mid_reach_bit4", cnt, 4);
        repeat (20) @(negedge clk);
        chk("mid_clk_low", int'(PSX_clk), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_clk", int'(PSX_clk), 1);
        chk("mid_rst_sel", int'(PSX_sel), 1);
        chk("mid_rst_cmd", int'(PSX_cmd), 1);
        chk("mid_rst_strobe", int'(HPB_reply_strobe), 0);
        reset = 1'b0;
        lows = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (HPB_reply_strobe || !PSX_sel) lows++;
        end
        chk("mid_quiet", lows, 0);

        send_byte(8'h3C, 1'b1, 8'h96, 0, 0, 8'h96, 1'b0, 100, 50);
        chk("post_rst_sel", int'(PSX_sel), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
